// File: rtl/rob_mp.sv
// Multi-port reorder buffer: in-order allocation, out-of-order completion,
// in-order multi-lane commit, occupancy-based backpressure and redirect flush.
module rob_mp #(
  parameter  int DEPTH  = 16,
  parameter  int ENQ_W  = 2,
  parameter  int WB_N   = 3,
  parameter  int CMT_W  = 2,
  parameter  int LREG_W = 5,
  parameter  int PREG_W = 6,
  parameter  int PC_W   = 48,
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ENQ_W-1:0]         enq_valid,
  input  logic [32*ENQ_W-1:0]      enq_instr,
  input  logic [LREG_W*ENQ_W-1:0]  enq_lrd,
  input  logic [PREG_W*ENQ_W-1:0]  enq_prd,
  input  logic [PREG_W*ENQ_W-1:0]  enq_old_prd,
  input  logic [PC_W*ENQ_W-1:0]    enq_pc,
  output logic                     enq_ready,
  output logic                     enq_robflag,
  output logic [IW-1:0]            enq_robidx,
  input  logic [WB_N-1:0]          wb_valid,
  input  logic [WB_N-1:0]          wb_robflag,
  input  logic [IW*WB_N-1:0]       wb_robidx,
  output logic [CMT_W-1:0]         cmt_valid,
  output logic [LREG_W*CMT_W-1:0]  cmt_lrd,
  output logic [PREG_W*CMT_W-1:0]  cmt_prd,
  output logic [PREG_W*CMT_W-1:0]  cmt_old_prd,
  output logic [32*CMT_W-1:0]      cmt_instr,
  output logic [PC_W*CMT_W-1:0]    cmt_pc,
  input  logic                     redirect_valid,
  input  logic                     redirect_robflag,
  input  logic [IW-1:0]            redirect_robidx,
  output logic [IW:0]              occupancy
);

  typedef logic [IW:0] ptr_t;

  ptr_t head_q, head_d, tail_q, tail_d;
  ptr_t occ, rptr, red_keep, red_span, cmt_cnt, enq_cnt;
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, flag_q, flag_d;
  logic [IW+1:0]    free_cnt;
  logic             enq_fire;

  logic [LREG_W-1:0] lrd_q     [DEPTH];
  logic [PREG_W-1:0] prd_q     [DEPTH];
  logic [PREG_W-1:0] old_prd_q [DEPTH];
  logic [31:0]       instr_q   [DEPTH];
  logic [PC_W-1:0]   pc_q      [DEPTH];

  logic [IW-1:0] cidx [CMT_W];
  ptr_t          eptr [ENQ_W];
  logic [IW-1:0] rel  [DEPTH];

  assign occ         = tail_q - head_q;
  assign occupancy   = occ;
  assign free_cnt    = (IW+2)'(DEPTH) - {1'b0, occ};
  assign enq_ready   = free_cnt >= (IW+2)'(ENQ_W);
  assign enq_robflag = tail_q[IW];
  assign enq_robidx  = tail_q[IW-1:0];
  assign enq_fire    = enq_ready & ~redirect_valid;

  // red_keep: entries head..redirect inclusive; red_span: entries redirect..tail-1
  assign rptr     = {redirect_robflag, redirect_robidx};
  assign red_keep = rptr - head_q + ptr_t'(1);
  assign red_span = tail_q - rptr;

  always_comb begin
    for (int k = 0; k < CMT_W; k++) cidx[k] = head_q[IW-1:0] + IW'(k);
    for (int i = 0; i < ENQ_W; i++) eptr[i] = tail_q + ptr_t'(i);
    for (int j = 0; j < DEPTH; j++) rel[j] = IW'(IW'(j) - redirect_robidx);
  end

  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < ENQ_W; i++) enq_cnt = enq_cnt + ptr_t'(enq_valid[i]);
  end

  // Commit lanes stop at the first not-done entry and never pass a redirect point
  always_comb begin
    logic run;
    run         = 1'b1;
    cmt_valid   = '0;
    cmt_lrd     = '0;
    cmt_prd     = '0;
    cmt_old_prd = '0;
    cmt_instr   = '0;
    cmt_pc      = '0;
    cmt_cnt     = '0;
    for (int k = 0; k < CMT_W; k++) begin
      run = run & valid_q[cidx[k]] & done_q[cidx[k]] &
            (~redirect_valid | (ptr_t'(k) < red_keep));
      cmt_valid[k] = run;
      if (run) begin
        cmt_lrd[k*LREG_W +: LREG_W]     = lrd_q[cidx[k]];
        cmt_prd[k*PREG_W +: PREG_W]     = prd_q[cidx[k]];
        cmt_old_prd[k*PREG_W +: PREG_W] = old_prd_q[cidx[k]];
        cmt_instr[k*32 +: 32]           = instr_q[cidx[k]];
        cmt_pc[k*PC_W +: PC_W]          = pc_q[cidx[k]];
        cmt_cnt                         = cmt_cnt + ptr_t'(1);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    flag_d  = flag_q;
    head_d  = head_q + cmt_cnt;
    tail_d  = tail_q;
    // A writeback only lands on a live entry allocated in the same pointer lap
    for (int p = 0; p < WB_N; p++) begin
      if (wb_valid[p] && valid_q[wb_robidx[p*IW +: IW]] &&
          (flag_q[wb_robidx[p*IW +: IW]] == wb_robflag[p]))
        done_d[wb_robidx[p*IW +: IW]] = 1'b1;
    end
    for (int k = 0; k < CMT_W; k++) begin
      if (cmt_valid[k]) begin
        valid_d[cidx[k]] = 1'b0;
        done_d[cidx[k]]  = 1'b0;
      end
    end
    if (redirect_valid) begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((rel[j] != '0) && ({1'b0, rel[j]} < red_span)) begin
          valid_d[j] = 1'b0;
          done_d[j]  = 1'b0;
        end
      end
      tail_d = rptr + ptr_t'(1);
    end else if (enq_ready) begin
      for (int i = 0; i < ENQ_W; i++) begin
        if (enq_valid[i]) begin
          valid_d[eptr[i][IW-1:0]] = 1'b1;
          done_d[eptr[i][IW-1:0]]  = 1'b0;
          flag_d[eptr[i][IW-1:0]]  = eptr[i][IW];
        end
      end
      tail_d = tail_q + enq_cnt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
      flag_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      flag_q  <= flag_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by valid_q alone
  always_ff @(posedge clock) begin
    if (enq_fire) begin
      for (int i = 0; i < ENQ_W; i++) begin
        if (enq_valid[i]) begin
          lrd_q[eptr[i][IW-1:0]]     <= enq_lrd[i*LREG_W +: LREG_W];
          prd_q[eptr[i][IW-1:0]]     <= enq_prd[i*PREG_W +: PREG_W];
          old_prd_q[eptr[i][IW-1:0]] <= enq_old_prd[i*PREG_W +: PREG_W];
          instr_q[eptr[i][IW-1:0]]   <= enq_instr[i*32 +: 32];
          pc_q[eptr[i][IW-1:0]]      <= enq_pc[i*PC_W +: PC_W];
        end
      end
    end
  end

  a_enq_contig: assert property (@(posedge clock) disable iff (reset)
    (enq_valid & (enq_valid + ENQ_W'(1))) == '0);

  a_redir_range: assert property (@(posedge clock) disable iff (reset)
    redirect_valid |-> (ptr_t'(rptr - head_q) < occ));

endmodule

// File: tb/tb_rob_mp.sv
// Directed bench for rob_mp (DEPTH=8): reset, commit, backpressure, wrap,
// stale writeback, redirect flush and same-cycle redirect commit.
module tb_rob_mp;
  localparam int DEPTH  = 8;
  localparam int ENQ_W  = 2;
  localparam int WB_N   = 3;
  localparam int CMT_W  = 2;
  localparam int LREG_W = 5;
  localparam int PREG_W = 6;
  localparam int PC_W   = 48;
  localparam int IW     = 3;

  logic                    clock;
  logic                    reset;
  logic [ENQ_W-1:0]        enq_valid;
  logic [32*ENQ_W-1:0]     enq_instr;
  logic [LREG_W*ENQ_W-1:0] enq_lrd;
  logic [PREG_W*ENQ_W-1:0] enq_prd;
  logic [PREG_W*ENQ_W-1:0] enq_old_prd;
  logic [PC_W*ENQ_W-1:0]   enq_pc;
  logic                    enq_ready;
  logic                    enq_robflag;
  logic [IW-1:0]           enq_robidx;
  logic [WB_N-1:0]         wb_valid;
  logic [WB_N-1:0]         wb_robflag;
  logic [IW*WB_N-1:0]      wb_robidx;
  logic [CMT_W-1:0]        cmt_valid;
  logic [LREG_W*CMT_W-1:0] cmt_lrd;
  logic [PREG_W*CMT_W-1:0] cmt_prd;
  logic [PREG_W*CMT_W-1:0] cmt_old_prd;
  logic [32*CMT_W-1:0]     cmt_instr;
  logic [PC_W*CMT_W-1:0]   cmt_pc;
  logic                    redirect_valid;
  logic                    redirect_robflag;
  logic [IW-1:0]           redirect_robidx;
  logic [IW:0]             occupancy;

  int vectors = 0;
  int miscompares = 0;

  rob_mp #(
    .DEPTH(DEPTH), .ENQ_W(ENQ_W), .WB_N(WB_N), .CMT_W(CMT_W),
    .LREG_W(LREG_W), .PREG_W(PREG_W), .PC_W(PC_W)
  ) dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_instr(enq_instr), .enq_lrd(enq_lrd),
    .enq_prd(enq_prd), .enq_old_prd(enq_old_prd), .enq_pc(enq_pc),
    .enq_ready(enq_ready), .enq_robflag(enq_robflag), .enq_robidx(enq_robidx),
    .wb_valid(wb_valid), .wb_robflag(wb_robflag), .wb_robidx(wb_robidx),
    .cmt_valid(cmt_valid), .cmt_lrd(cmt_lrd), .cmt_prd(cmt_prd),
    .cmt_old_prd(cmt_old_prd), .cmt_instr(cmt_instr), .cmt_pc(cmt_pc),
    .redirect_valid(redirect_valid), .redirect_robflag(redirect_robflag),
    .redirect_robidx(redirect_robidx), .occupancy(occupancy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    enq_valid        = '0;
    enq_instr        = '0;
    enq_lrd          = '0;
    enq_prd          = '0;
    enq_old_prd      = '0;
    enq_pc           = '0;
    wb_valid         = '0;
    wb_robflag       = '0;
    wb_robidx        = '0;
    redirect_valid   = 1'b0;
    redirect_robflag = 1'b0;
    redirect_robidx  = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Lane 0 gets pc0, lane 1 gets pc0+4; other fields derived from the PC
  task automatic enq2(input logic [1:0] v, input logic [47:0] pc0);
    enq_valid   = v;
    enq_pc      = {pc0 + 48'd4, pc0};
    enq_instr   = {pc0[31:0] + 32'd4, pc0[31:0]};
    enq_lrd     = {pc0[6:2] + 5'd1, pc0[6:2]};
    enq_prd     = {pc0[7:2] + 6'd1, pc0[7:2]};
    enq_old_prd = {6'd41, 6'd40};
  endtask

  task automatic wb(input int p, input logic f, input logic [2:0] idx);
    wb_valid[p]         = 1'b1;
    wb_robflag[p]       = f;
    wb_robidx[3*p +: 3] = idx;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk_vec("rst_ready",  128'(enq_ready),   128'(1));
    chk_vec("rst_robidx", 128'(enq_robidx),  128'(0));
    chk_vec("rst_flag",   128'(enq_robflag), 128'(0));
    chk_vec("rst_cmt",    128'(cmt_valid),   128'(0));
    chk_vec("rst_occ",    128'(occupancy),   128'(0));
    chk_vec("rst_cmtpc",  128'(cmt_pc),      128'(0));

    // Basic enqueue, out-of-order writeback, dual commit
    enq2(2'b11, 48'h1000); step();
    chk_vec("enq1_occ", 128'(occupancy),  128'(2));
    chk_vec("enq1_idx", 128'(enq_robidx), 128'(2));
    enq2(2'b11, 48'h1008); step();
    chk_vec("enq2_occ", 128'(occupancy),  128'(4));
    chk_vec("enq2_idx", 128'(enq_robidx), 128'(4));
    idle(); wb(0, 1'b0, 3'd1); step();
    chk_vec("wb1_nocmt", 128'(cmt_valid), 128'(0));
    idle(); wb(0, 1'b0, 3'd0); step();
    chk_vec("wb0_cmt",    128'(cmt_valid), 128'(2'b11));
    chk_vec("wb0_cmtpc",  128'(cmt_pc),    128'({48'h1004, 48'h1000}));
    chk_vec("wb0_cmtlrd", 128'(cmt_lrd),   128'({5'd1, 5'd0}));
    chk_vec("wb0_instr",  128'(cmt_instr), 128'({32'h1004, 32'h1000}));
    chk_vec("wb0_occ",    128'(occupancy), 128'(4));
    idle(); step();
    chk_vec("post_cmt_occ", 128'(occupancy), 128'(2));
    chk_vec("post_cmt_cmt", 128'(cmt_valid), 128'(0));
    idle(); wb(1, 1'b0, 3'd2); step();
    chk_vec("part_cmt",   128'(cmt_valid),        128'(2'b01));
    chk_vec("part_cmtpc", 128'(cmt_pc[47:0]),     128'(48'h1008));

    // Asynchronous reset in the middle of a pending commit
    reset = 1'b1;
    #1;
    chk_vec("arst_cmt", 128'(cmt_valid), 128'(0));
    chk_vec("arst_occ", 128'(occupancy), 128'(0));
    chk_vec("arst_pc",  128'(cmt_pc),    128'(0));
    idle(); step();
    reset = 1'b0;
    step();
    chk_vec("arst_after_cmt", 128'(cmt_valid),  128'(0));
    chk_vec("arst_after_idx", 128'(enq_robidx), 128'(0));

    // Fill to full, wrap the tail, then a blocked request
    for (int c = 0; c < 4; c++) begin
      enq2(2'b11, 48'h2000 + 48'(8*c)); step();
      chk_vec("fill_idx", 128'(enq_robidx), 128'(((c+1)*2) % 8));
      chk_vec("fill_occ", 128'(occupancy),  128'((c+1)*2));
    end
    chk_vec("full_ready", 128'(enq_ready),   128'(0));
    chk_vec("full_flag",  128'(enq_robflag), 128'(1));
    enq2(2'b11, 48'h2040); step();
    chk_vec("blocked_idx",  128'(enq_robidx),  128'(0));
    chk_vec("blocked_flag", 128'(enq_robflag), 128'(1));
    chk_vec("blocked_occ",  128'(occupancy),   128'(8));

    // Drain four, refill across the wrap, stale-flag writeback ignored
    idle(); wb(0, 1'b0, 3'd0); wb(1, 1'b0, 3'd1); wb(2, 1'b0, 3'd2); step();
    chk_vec("drain_cmt",  128'(cmt_valid), 128'(2'b11));
    chk_vec("drain_pc",   128'(cmt_pc),    128'({48'h2004, 48'h2000}));
    idle(); wb(0, 1'b0, 3'd3); step();
    chk_vec("drain2_cmt",   128'(cmt_valid), 128'(2'b11));
    chk_vec("drain2_pc",    128'(cmt_pc),    128'({48'h200C, 48'h2008}));
    chk_vec("drain2_occ",   128'(occupancy), 128'(6));
    chk_vec("drain2_ready", 128'(enq_ready), 128'(1));
    idle(); enq2(2'b11, 48'h3000); step();
    chk_vec("wrap_idx",  128'(enq_robidx),  128'(2));
    chk_vec("wrap_flag", 128'(enq_robflag), 128'(1));
    chk_vec("wrap_occ",  128'(occupancy),   128'(6));
    chk_vec("wrap_cmt",  128'(cmt_valid),   128'(0));
    idle(); enq2(2'b11, 48'h3008); step();
    chk_vec("refull_occ",   128'(occupancy),  128'(8));
    chk_vec("refull_ready", 128'(enq_ready),  128'(0));
    chk_vec("refull_idx",   128'(enq_robidx), 128'(4));
    idle(); wb(0, 1'b0, 3'd4); wb(1, 1'b0, 3'd5); wb(2, 1'b0, 3'd6); step();
    chk_vec("old_cmt", 128'(cmt_valid), 128'(2'b11));
    idle(); wb(0, 1'b0, 3'd7); step();
    chk_vec("old2_cmt", 128'(cmt_valid), 128'(2'b11));
    chk_vec("old2_pc",  128'(cmt_pc),    128'({48'h201C, 48'h2018}));
    idle(); step();
    chk_vec("lap_occ", 128'(occupancy), 128'(4));
    chk_vec("lap_cmt", 128'(cmt_valid), 128'(0));
    idle(); wb(0, 1'b0, 3'd0); step();
    chk_vec("stale_wb", 128'(cmt_valid), 128'(0));
    idle(); wb(0, 1'b1, 3'd0); step();
    chk_vec("fresh_wb",    128'(cmt_valid),    128'(2'b01));
    chk_vec("fresh_wb_pc", 128'(cmt_pc[47:0]), 128'(48'h3000));
    idle(); step();
    chk_vec("fresh_occ", 128'(occupancy), 128'(3));

    // Redirect with same-cycle enqueue and writeback to a flushed entry
    reset = 1'b1; step(); reset = 1'b0; idle(); step();
    for (int c = 0; c < 3; c++) begin
      enq2(2'b11, 48'h4000 + 48'(8*c)); step();
    end
    chk_vec("six_occ", 128'(occupancy),  128'(6));
    chk_vec("six_idx", 128'(enq_robidx), 128'(6));
    idle();
    redirect_valid = 1'b1; redirect_robflag = 1'b0; redirect_robidx = 3'd2;
    enq2(2'b11, 48'h5000); wb(0, 1'b0, 3'd4);
    step(); idle();
    chk_vec("redir_idx",  128'(enq_robidx),  128'(3));
    chk_vec("redir_occ",  128'(occupancy),   128'(3));
    chk_vec("redir_flag", 128'(enq_robflag), 128'(0));
    enq2(2'b11, 48'h6000); step(); idle();
    chk_vec("post_redir_idx", 128'(enq_robidx), 128'(5));
    chk_vec("post_redir_occ", 128'(occupancy),  128'(5));
    wb(0, 1'b0, 3'd0); wb(1, 1'b0, 3'd1); wb(2, 1'b0, 3'd2); step();
    chk_vec("redir_c1", 128'(cmt_valid), 128'(2'b11));
    idle(); wb(0, 1'b0, 3'd3); step();
    chk_vec("redir_c2",    128'(cmt_valid), 128'(2'b11));
    chk_vec("redir_c2_pc", 128'(cmt_pc),    128'({48'h6000, 48'h4008}));
    idle(); step();
    chk_vec("flushed_wb", 128'(cmt_valid), 128'(0));
    chk_vec("flushed_occ", 128'(occupancy), 128'(1));

    // Redirect on a done head entry commits it in the same cycle
    reset = 1'b1; step(); reset = 1'b0; idle(); step();
    enq2(2'b11, 48'h7000); step(); idle();
    wb(0, 1'b0, 3'd0); step(); idle();
    chk_vec("rh_pre_cmt", 128'(cmt_valid), 128'(2'b01));
    redirect_valid = 1'b1; redirect_robflag = 1'b0; redirect_robidx = 3'd0;
    #1;
    chk_vec("rh_cmt",    128'(cmt_valid),    128'(2'b01));
    chk_vec("rh_cmt_pc", 128'(cmt_pc[47:0]), 128'(48'h7000));
    step(); idle();
    chk_vec("rh_occ", 128'(occupancy),  128'(0));
    chk_vec("rh_idx", 128'(enq_robidx), 128'(1));
    chk_vec("rh_cmt_after", 128'(cmt_valid), 128'(0));
    enq2(2'b01, 48'h8000); step(); idle();
    chk_vec("single_idx", 128'(enq_robidx), 128'(2));
    chk_vec("single_occ", 128'(occupancy),  128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
